// File: rtl/serial_pkg.sv
// Shared definitions for the AXI-Stream to SPI-mode-0 serial transmitter:
// FSM state encoding, SPI mode constant and default geometry.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CTS = 3'd1,
        ST_SETUP    = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_GAP      = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

    localparam int SPI_MODE         = 0;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_CS_SETUP     = 2;
    localparam int DEF_CS_IDLE      = 2;

endpackage

// File: rtl/serial_sck_gen.sv
// Serial clock divider: sck toggles every CLK_DIV enabled cycles; the pulses
// flag the cycle whose closing edge will raise or lower sck.
module serial_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal   = en && (div_cnt == DIV_LAST);
    assign rise_pulse = terminal && !sck;
    assign fall_pulse = terminal && sck;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_serial_tx.sv
// AXI-Stream to SPI mode 0 master transmitter, MSB first, one word per cts grant.
// Define SERIAL_TX_CTS_EN to gate word acceptance on serial_cts; otherwise cts is ignored.
module axis_serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_IDLE    = DEF_CS_IDLE
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  serial_mosi,
    output logic                  serial_sck,
    output logic                  serial_cs,
    input  logic                  serial_cts,
    output state_t                dbg_state
);

    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int WAIT_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] IDLE_LAST  = WAIT_W'(CS_IDLE - 1);

    // Handshake: a word transfers on the rising aclk edge where s_axis_tvalid and
    // s_axis_tready are both high; tready depends only on state and cts, never tvalid.

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  last_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  cts_ok;
    logic                  load;
    logic                  rise_pulse, fall_pulse;

`ifdef SERIAL_TX_CTS_EN
    assign cts_ok = serial_cts;
`else
    logic cts_unused;
    assign cts_unused = serial_cts;
    assign cts_ok     = 1'b1;
`endif

    serial_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk        (aclk),
        .reset      (reset),
        .en         (state_q == ST_SHIFT),
        .clr        (state_q != ST_SHIFT),
        .sck        (serial_sck),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_tready = cts_ok && !reset;
                if (s_axis_tvalid && cts_ok && !reset) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_WAIT_CTS: begin
                // Within a packet cs is already low, so skip the setup delay.
                s_axis_tready = cts_ok && !reset;
                if (s_axis_tvalid && cts_ok && !reset) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SETUP:   if (wait_cnt == SETUP_LAST) state_d = ST_SHIFT;
            ST_SHIFT:   if (fall_pulse && bit_cnt == BIT_LAST) state_d = ST_GAP;
            ST_GAP:     state_d = last_q ? ST_RELEASE : ST_WAIT_CTS;
            ST_RELEASE: if (wait_cnt == IDLE_LAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg    <= '0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                shreg   <= s_axis_tdata;
                last_q  <= s_axis_tlast;
                bit_cnt <= '0;
            end else if (state_q == ST_SHIFT) begin
                if (rise_pulse) bit_cnt <= bit_cnt + 1'b1;
                // Next bit appears as sck falls, giving a full half-period either side of the rise.
                if (fall_pulse) shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == ST_SETUP || state_q == ST_RELEASE)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign serial_cs   = (state_q == ST_IDLE) || (state_q == ST_RELEASE);
    assign serial_mosi = shreg[DATA_WIDTH-1];
    assign dbg_state   = state_q;

endmodule
